usb_crc_rx_check: RTL and testbench

//  Parametrised receive-side USB CRC checker for the downstream SIE; supersedes the fixed CRC16 block.

---
 rtl/usb_crc_pkg.sv | 19 +
 rtl/crc_lfsr_step.sv | 19 +
 rtl/usb_crc_rx_check.sv | 131 +++++++++++++
 tb/tb_usb_crc_rx_check.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared USB CRC constants and the receive-checker state type.
package usb_crc_pkg;

  typedef enum logic [1:0] {
    CRC_IDLE,
    CRC_SKIP,
    CRC_CALC
  } crc_state_e;

  // Polynomials are MSB-first with the x^WIDTH term implicit.
  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // Sync byte plus PID byte precede the CRC-covered fields.
  localparam int unsigned USB_SKIP_BITS = 16;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial step of an MSB-first CRC LFSR; also used by the transmit-side generator.
module crc_lfsr_step #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_out
);

  logic fb;

  // Shift left and fold in the polynomial when the outgoing bit differs from the input bit.
  always_comb begin
    fb      = bit_in ^ crc_in[WIDTH-1];
    crc_out = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/usb_crc_rx_check.sv
// Receive-side USB CRC checker: skips sync+PID, runs the LFSR over unstuffed payload bits,
// and issues a one-cycle verdict after EOP together with bit count and overflow status.
module usb_crc_rx_check
  import usb_crc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(CRC16_POLY),
  parameter logic [WIDTH-1:0] INIT      = '1,
  parameter logic [WIDTH-1:0] RESIDUE   = WIDTH'(CRC16_RESIDUE),
  parameter int unsigned      SKIP_BITS = USB_SKIP_BITS,
  parameter int unsigned      MAX_BITS  = 8208,
  parameter int unsigned      CNT_W     = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  input  logic             is_stuffed,
  input  logic             in_transmission,
  input  logic             end_transmission,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic [WIDTH-1:0] crc_reg,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow
);

  localparam int unsigned SkipW = $clog2(SKIP_BITS + 1);

  crc_state_e       state_q, state_d;
  logic [SkipW-1:0] skip_cnt_q, skip_cnt_d;
  logic [WIDTH-1:0] crc_q, crc_d, crc_next;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             overflow_q, overflow_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_valid_q, crc_valid_d;
  logic             bit_strobe, eop_strobe;

  // EOP takes priority over a data bit offered in the same bit time.
  assign bit_strobe = en & in_transmission & ~is_stuffed & ~end_transmission;
  assign eop_strobe = en & end_transmission;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (serial_in),
    .crc_out (crc_next)
  );

  // Next-state: packet framing, skip/bit counting, LFSR update and verdict.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    crc_d       = crc_q;
    bit_count_d = bit_count_q;
    overflow_d  = overflow_q;
    crc_ok_d    = crc_ok_q;
    crc_valid_d = 1'b0;
    unique case (state_q)
      CRC_IDLE: begin
        // First bit of a packet is also skip bit 1; EOP here is ignored.
        if (bit_strobe) begin
          state_d     = (SKIP_BITS > 1) ? CRC_SKIP : CRC_CALC;
          skip_cnt_d  = SkipW'(1);
          crc_d       = INIT;
          bit_count_d = '0;
          overflow_d  = 1'b0;
          crc_ok_d    = 1'b0;
        end
      end
      CRC_SKIP: begin
        if (eop_strobe) begin
          // Runt packet: never reached the CRC-covered fields.
          state_d     = CRC_IDLE;
          crc_valid_d = 1'b1;
          crc_ok_d    = 1'b0;
        end else if (bit_strobe) begin
          skip_cnt_d = skip_cnt_q + SkipW'(1);
          if (skip_cnt_q == SkipW'(SKIP_BITS - 1)) begin
            state_d = CRC_CALC;
          end
        end
      end
      CRC_CALC: begin
        if (eop_strobe) begin
          state_d     = CRC_IDLE;
          crc_valid_d = 1'b1;
          crc_ok_d    = ~overflow_q & (bit_count_q >= CNT_W'(WIDTH)) & (crc_q == RESIDUE);
        end else if (bit_strobe) begin
          if (bit_count_q == CNT_W'(MAX_BITS)) begin
            overflow_d = 1'b1;
          end else begin
            crc_d       = crc_next;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = CRC_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CRC_IDLE;
      skip_cnt_q  <= '0;
      crc_q       <= INIT;
      bit_count_q <= '0;
      overflow_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      crc_q       <= crc_d;
      bit_count_q <= bit_count_d;
      overflow_q  <= overflow_d;
      crc_ok_q    <= crc_ok_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign crc_valid = crc_valid_q;
  assign crc_ok    = crc_ok_q;
  assign crc_reg   = crc_q;
  assign bit_count = bit_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_usb_crc_rx_check.sv
// Bench for usb_crc_rx_check: CRC16, CRC5 and a small-MAX_BITS CRC16 instance share one input
// stream; expectations come from a polynomial long-division model of the CRC.
module tb_usb_crc_rx_check;
  import usb_crc_pkg::*;

  logic clk = 1'b0;
  logic rst, en, serial_in, is_stuffed, in_transmission, end_transmission;

  logic        valid16, ok16, ovf16;
  logic [15:0] reg16;
  logic [13:0] cnt16;
  logic        valid5, ok5, ovf5;
  logic [4:0]  reg5;
  logic [13:0] cnt5;
  logic        valids, oks, ovfs;
  logic [15:0] regs;
  logic [5:0]  cnts;

  always #5 clk = ~clk;

  usb_crc_rx_check u_dut16 (
    .clk(clk), .rst(rst), .en(en), .serial_in(serial_in), .is_stuffed(is_stuffed),
    .in_transmission(in_transmission), .end_transmission(end_transmission),
    .crc_valid(valid16), .crc_ok(ok16), .crc_reg(reg16), .bit_count(cnt16), .overflow(ovf16)
  );

  usb_crc_rx_check #(
    .WIDTH(5), .POLY(CRC5_POLY), .RESIDUE(CRC5_RESIDUE)
  ) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .serial_in(serial_in), .is_stuffed(is_stuffed),
    .in_transmission(in_transmission), .end_transmission(end_transmission),
    .crc_valid(valid5), .crc_ok(ok5), .crc_reg(reg5), .bit_count(cnt5), .overflow(ovf5)
  );

  usb_crc_rx_check #(
    .MAX_BITS(32)
  ) u_dut16s (
    .clk(clk), .rst(rst), .en(en), .serial_in(serial_in), .is_stuffed(is_stuffed),
    .in_transmission(in_transmission), .end_transmission(end_transmission),
    .crc_valid(valids), .crc_ok(oks), .crc_reg(regs), .bit_count(cnts), .overflow(ovfs)
  );

  typedef struct {
    bit b;
    bit st;
  } sym_t;

  typedef struct {
    string       name;
    int          nskip;
    int          nbits;
    logic [63:0] bits;
    int          dut;
    logic        exp_ok;
    int          exp_cnt;
  } vec_t;

  sym_t stream[$];
  bit   pay[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          cfg_w   [3] = '{16, 5, 16};
  logic [15:0] cfg_poly[3] = '{16'h8005, 16'h0005, 16'h8005};
  logic [15:0] cfg_res [3] = '{16'h800D, 16'h000C, 16'h800D};
  int          cfg_max [3] = '{8208, 8208, 32};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of (INIT*x^n + M(x)*x^w) mod G, by long division over a coefficient array.
  function automatic logic [15:0] crc_model(input int w, input logic [15:0] poly, input int n);
    bit c [0:4095];
    logic [15:0] r;
    for (int i = 0; i < 4096; i++) c[i] = 1'b0;
    for (int k = 0; k < w; k++) c[n+k] ^= 1'b1;
    for (int i = 0; i < n; i++) c[n-1-i+w] ^= pay[i];
    for (int d = n + w - 1; d >= w; d--) begin
      if (c[d]) begin
        c[d] = 1'b0;
        for (int k = 0; k < w; k++) c[d-w+k] ^= poly[k];
      end
    end
    r = '0;
    for (int k = 0; k < w; k++) r[k] = c[k];
    return r;
  endfunction

  task automatic get_out(input int k, output logic [31:0] v, output logic [31:0] ok,
                         output logic [31:0] cnt, output logic [31:0] rg, output logic [31:0] ov);
    case (k)
      0:       begin v = valid16; ok = ok16; cnt = cnt16; rg = reg16; ov = ovf16; end
      1:       begin v = valid5;  ok = ok5;  cnt = cnt5;  rg = reg5;  ov = ovf5;  end
      default: begin v = valids;  ok = oks;  cnt = cnts;  rg = regs;  ov = ovfs;  end
    endcase
  endtask

  task automatic drive(input bit b, input bit st);
    en = 1'b1; in_transmission = 1'b1; end_transmission = 1'b0;
    serial_in = b; is_stuffed = st;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // en low with junk on every other input: nothing may move.
  task automatic gap();
    en = 1'b0; serial_in = 1'($urandom); is_stuffed = 1'($urandom);
    end_transmission = 1'($urandom); in_transmission = 1'($urandom);
    @(posedge clk); #1;
    end_transmission = 1'b0;
  endtask

  task automatic eop(input bit b);
    en = 1'b1; in_transmission = 1'b1; end_transmission = 1'b1;
    serial_in = b; is_stuffed = 1'b0;
    @(posedge clk); #1;
    en = 1'b0; end_transmission = 1'b0; in_transmission = 1'b0;
  endtask

  task automatic play(input bit gaps);
    foreach (stream[i]) begin
      if (gaps && $urandom_range(0, 4) == 0) gap();
      drive(stream[i].b, stream[i].st);
    end
  endtask

  function automatic void push_pay_as_stream();
    foreach (pay[i]) begin
      if ($urandom_range(0, 7) == 0) stream.push_back('{b: 1'($urandom), st: 1'b1});
      stream.push_back('{b: pay[i], st: 1'b0});
    end
  endfunction

  function automatic void push_skip(input int m);
    for (int i = 0; i < m; i++) stream.push_back('{b: 1'($urandom), st: 1'b0});
  endfunction

  function automatic void append_crc(input int w, input logic [15:0] poly);
    logic [15:0] r;
    r = crc_model(w, poly, pay.size());
    for (int k = w - 1; k >= 0; k--) pay.push_back(~r[k]);
  endfunction

  // Called one cycle after the EOP strobe: compare all instances with the model.
  task automatic check_pkt(input string tag);
    int t, n, nsh;
    logic [15:0] er;
    logic eok, eovf, calc;
    logic [31:0] v, ok, cnt, rg, ov;
    t = 0;
    pay.delete();
    foreach (stream[i]) begin
      if (!stream[i].st) begin
        if (t >= 16) pay.push_back(stream[i].b);
        t++;
      end
    end
    if (t == 0) begin
      chk({tag, " idle-eop valid"}, 32'(valid16), 32'd0);
      return;
    end
    calc = (t >= 16);
    n = calc ? t - 16 : 0;
    for (int k = 0; k < 3; k++) begin
      nsh  = (n > cfg_max[k]) ? cfg_max[k] : n;
      eovf = (n > cfg_max[k]);
      er   = calc ? crc_model(cfg_w[k], cfg_poly[k], nsh) : 16'((1 << cfg_w[k]) - 1);
      eok  = calc && !eovf && (nsh >= cfg_w[k]) && (er == cfg_res[k]);
      get_out(k, v, ok, cnt, rg, ov);
      chk($sformatf("%s/d%0d valid", tag, k), v, 32'd1);
      chk($sformatf("%s/d%0d ok", tag, k), ok, 32'(eok));
      chk($sformatf("%s/d%0d cnt", tag, k), cnt, 32'(nsh));
      chk($sformatf("%s/d%0d reg", tag, k), rg, 32'(er));
      chk($sformatf("%s/d%0d ovf", tag, k), ov, 32'(eovf));
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] v, ok, cnt, rg, ov;
    rst = 1'b1; en = 1'b0; serial_in = 1'b0; is_stuffed = 1'b0;
    in_transmission = 1'b0; end_transmission = 1'b0;

    vecs[0] = '{"data0_zero", 16, 16, 64'h0,    0, 1'b1, 16};
    vecs[1] = '{"token_ok",   16, 16, 64'hEF15, 1, 1'b1, 16};
    vecs[2] = '{"token_flip", 16, 16, 64'hEF14, 1, 1'b0, 16};
    vecs[3] = '{"runt10",     10, 0,  64'h0,    0, 1'b0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst reg16", 32'(reg16), 32'hFFFF);
    chk("rst reg5", 32'(reg5), 32'h1F);
    chk("rst cnt16", 32'(cnt16), 32'd0);
    chk("rst valid", 32'({valid16, valid5, valids}), 32'd0);
    chk("rst ok", 32'({ok16, ok5, oks}), 32'd0);
    chk("rst ovf", 32'({ovf16, ovf5, ovfs}), 32'd0);
    rst = 1'b0;

    // Directed packet table.
    for (int i = 0; i < 4; i++) begin
      stream.delete();
      push_skip(vecs[i].nskip);
      for (int j = 0; j < vecs[i].nbits; j++) stream.push_back('{b: vecs[i].bits[j], st: 1'b0});
      play(1'b0);
      eop(1'b0);
      get_out(vecs[i].dut, v, ok, cnt, rg, ov);
      chk({vecs[i].name, " valid"}, v, 32'd1);
      chk({vecs[i].name, " ok"}, ok, 32'(vecs[i].exp_ok));
      chk({vecs[i].name, " cnt"}, cnt, 32'(vecs[i].exp_cnt));
      gap();
      get_out(vecs[i].dut, v, ok, cnt, rg, ov);
      chk({vecs[i].name, " valid drop"}, v, 32'd0);
      chk({vecs[i].name, " ok held"}, ok, 32'(vecs[i].exp_ok));
    end

    // 4-byte payload with a stuff bit after six ones, plus CRC16.
    stream.delete(); pay.delete();
    push_skip(16);
    for (int j = 0; j < 32; j++) begin
      logic [31:0] data;
      data = 32'h5634_12FF;
      pay.push_back(data[j]);
    end
    append_crc(16, 16'h8005);
    foreach (pay[i]) begin
      stream.push_back('{b: pay[i], st: 1'b0});
      if (i == 5) stream.push_back('{b: 1'b0, st: 1'b1});
    end
    play(1'b0);
    eop(1'b0);
    chk("stuffed ok16", 32'(ok16), 32'd1);
    chk("stuffed cnt16", 32'(cnt16), 32'd48);
    chk("stuffed ovf small", 32'(ovfs), 32'd1);
    check_pkt("stuffed");

    // 40 payload bits into the MAX_BITS=32 instance.
    stream.delete();
    push_skip(16);
    push_skip(40);
    play(1'b0);
    eop(1'b0);
    chk("ovf40 flag", 32'(ovfs), 32'd1);
    chk("ovf40 cnt", 32'(cnts), 32'd32);
    chk("ovf40 ok", 32'(oks), 32'd0);
    gap();

    // EOP and a data bit in the same bit time: bit not counted.
    stream.delete();
    push_skip(24);
    play(1'b0);
    eop(1'b1);
    chk("eop+bit cnt", 32'(cnt16), 32'd8);
    check_pkt("eop+bit");

    // en low for 5 clocks mid-packet holds everything.
    stream.delete();
    push_skip(26);
    play(1'b0);
    repeat (5) gap();
    pay.delete();
    for (int i = 16; i < 26; i++) pay.push_back(stream[i].b);
    chk("hold cnt", 32'(cnt16), 32'd10);
    chk("hold reg", 32'(reg16), 32'(crc_model(16, 16'h8005, 10)));
    eop(1'b0);
    check_pkt("hold");

    // Reset mid-CALC after the small instance has overflowed.
    stream.delete();
    push_skip(56);
    play(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst reg16", 32'(reg16), 32'hFFFF);
    chk("midrst reg5", 32'(reg5), 32'h1F);
    chk("midrst cnt", 32'({cnt16, cnts}), 32'd0);
    chk("midrst flags", 32'({valid16, ok16, ovfs, oks}), 32'd0);
    stream.delete();
    push_skip(20);
    play(1'b0);
    eop(1'b0);
    check_pkt("after-rst");
    gap();

    // Randomized packets against the model.
    for (int it = 0; it < 60; it++) begin
      int mode, sel;
      mode = $urandom_range(0, 2);
      sel  = $urandom_range(0, 9);
      stream.delete(); pay.delete();
      if (sel == 0) begin
        push_skip($urandom_range(0, 15));
      end else begin
        for (int j = $urandom_range(0, 48); j > 0; j--) pay.push_back(1'($urandom));
        if (mode == 1) append_crc(16, 16'h8005);
        if (mode == 2) append_crc(5, 16'h0005);
        push_skip(16);
        push_pay_as_stream();
      end
      play(1'b1);
      eop(1'($urandom));
      check_pkt($sformatf("rand%0d", it));
      gap();
      chk($sformatf("rand%0d valid drop", it), 32'({valid16, valid5, valids}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
